lp_pipe_issue_ctrl: RTL and testbench

Initiator and collector for a DesignWare low-power pipelined arithmetic unit that uses the launch/accept_n/arrive/push_out_n protocol. Upstream requests enter on a valid/ready port. The block drives `launch` and a sequential `launch_id`, bounds the number of operations in flight, and captures results into a small FIFO. It drives `accept_n` from FIFO fullness to back-pressure the pipe, and presents results in order on a valid/ready response port. Operands route straight from the requester to the arithmetic unit; this block controls only handshake, IDs and result buffering.

---
 rtl/lp_pipe_issue_if.sv | 41 ++++
 rtl/lp_pipe_issue_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lp_pipe_issue_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lp_pipe_issue_if.sv
// Handshake bundle between the issue controller, the requester, the pipelined
// arithmetic unit and the response consumer.
interface lp_pipe_issue_if #(
   parameter int data_width      = 32,
   parameter int id_width        = 8,
   parameter int max_outstanding = 8,
   parameter int depth           = 4
);
   localparam int IF_W = $clog2(max_outstanding + 1);

   logic                  req_valid;
   logic                  req_ready;
   logic                  launch;
   logic [id_width-1:0]   launch_id;
   logic                  pipe_full;
   logic                  pipe_ovf;
   logic                  accept_n;
   logic                  arrive;
   logic [id_width-1:0]   arrive_id;
   logic                  push_out_n;
   logic [data_width-1:0] res_data;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [data_width-1:0] rsp_data;
   logic [id_width-1:0]   rsp_id;
   logic [IF_W-1:0]       in_flight;
   logic                  err_ovf;
   logic                  err_id;

   modport master (
      output req_valid, pipe_full, pipe_ovf, arrive, arrive_id, push_out_n, res_data, rsp_ready,
      input  req_ready, launch, launch_id, accept_n, rsp_valid, rsp_data, rsp_id, in_flight,
             err_ovf, err_id
   );

   modport slave (
      input  req_valid, pipe_full, pipe_ovf, arrive, arrive_id, push_out_n, res_data, rsp_ready,
      output req_ready, launch, launch_id, accept_n, rsp_valid, rsp_data, rsp_id, in_flight,
             err_ovf, err_id
   );
endinterface

// File: rtl/lp_pipe_issue_ctrl.sv
// Launch/collect controller for a low-power pipelined arithmetic unit with an in-order result FIFO.
// Optional feature: define LP_PIPE_ISSUE_ID_CHECK_EN to build the in-order arrive_id checker.
module lp_pipe_issue_ctrl #(
   parameter int data_width      = 32,
   parameter int id_width        = 8,
   parameter int max_outstanding = 8,
   parameter int depth           = 4
) (
   input logic              clk,
   input logic              rst_n,
   lp_pipe_issue_if.slave   bus
);
   localparam int IF_W  = $clog2(max_outstanding + 1);
   localparam int PTR_W = $clog2(depth);
   localparam int CNT_W = $clog2(depth + 1);
   localparam int ENT_W = id_width + data_width;

   logic [id_width-1:0] next_id_q, next_id_d;
   logic [IF_W-1:0]     in_flight_q, in_flight_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ENT_W-1:0]    mem_q [depth];
   logic                err_ovf_q, err_ovf_d;

   logic req_ready_s, launch_s, full_s, empty_s, push_s, cap_s, pop_s;
   logic arrive_unused_s;

   assign full_s      = (cnt_q == CNT_W'(depth));
   assign empty_s     = (cnt_q == CNT_W'(0));
   assign req_ready_s = !bus.pipe_full && (in_flight_q < IF_W'(max_outstanding));
   assign launch_s    = bus.req_valid && req_ready_s;
   // A push into a full FIFO is dropped but still retires an in-flight op.
   assign push_s      = !bus.push_out_n;
   assign cap_s       = push_s && !full_s;
   assign pop_s       = !empty_s && bus.rsp_ready;

   // arrive is informational; capture is keyed on push_out_n alone.
   assign arrive_unused_s = bus.arrive;

   // Next-state logic for IDs, in-flight count, FIFO pointers and overflow flag.
   always_comb begin
      next_id_d   = next_id_q;
      in_flight_d = in_flight_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      err_ovf_d   = err_ovf_q;

      if (launch_s) begin
         next_id_d = next_id_q + id_width'(1);
      end else begin
         next_id_d = next_id_q;
      end

      case ({launch_s, push_s})
         2'b10:   in_flight_d = in_flight_q + IF_W'(1);
         2'b01: begin
            if (in_flight_q != IF_W'(0)) begin
               in_flight_d = in_flight_q - IF_W'(1);
            end else begin
               in_flight_d = in_flight_q;
            end
         end
         default: in_flight_d = in_flight_q;
      endcase

      if (cap_s) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({cap_s, pop_s})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase

      if (bus.pipe_ovf || (push_s && full_s)) begin
         err_ovf_d = 1'b1;
      end else begin
         err_ovf_d = err_ovf_q;
      end
   end

   // Control state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         next_id_q   <= id_width'(0);
         in_flight_q <= IF_W'(0);
         wr_ptr_q    <= PTR_W'(0);
         rd_ptr_q    <= PTR_W'(0);
         cnt_q       <= CNT_W'(0);
         err_ovf_q   <= 1'b0;
      end else begin
         next_id_q   <= next_id_d;
         in_flight_q <= in_flight_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         err_ovf_q   <= err_ovf_d;
      end
   end

   // Result storage; cleared on reset so the head reads zero while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < depth; i++) begin
            mem_q[i] <= ENT_W'(0);
         end
      end else if (cap_s) begin
         mem_q[wr_ptr_q] <= {bus.arrive_id, bus.res_data};
      end else begin
         mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
   end

`ifdef LP_PIPE_ISSUE_ID_CHECK_EN
   logic [id_width-1:0] exp_id_q, exp_id_d;
   logic                err_id_q, err_id_d;

   // Expected-ID tracking; the pipe is in-order so any mismatch is an error.
   always_comb begin
      exp_id_d = exp_id_q;
      err_id_d = err_id_q;
      if (cap_s) begin
         exp_id_d = exp_id_q + id_width'(1);
         if (bus.arrive_id != exp_id_q) begin
            err_id_d = 1'b1;
         end else begin
            err_id_d = err_id_q;
         end
      end else begin
         exp_id_d = exp_id_q;
      end
   end

   // ID checker registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_id_q <= id_width'(0);
         err_id_q <= 1'b0;
      end else begin
         exp_id_q <= exp_id_d;
         err_id_q <= err_id_d;
      end
   end

   assign bus.err_id = err_id_q;
`else
   assign bus.err_id = 1'b0;
`endif

   assign bus.req_ready = req_ready_s;
   assign bus.launch    = launch_s;
   assign bus.launch_id = next_id_q;
   assign bus.accept_n  = full_s;
   assign bus.rsp_valid = !empty_s;
   assign bus.rsp_data  = mem_q[rd_ptr_q][data_width-1:0];
   assign bus.rsp_id    = mem_q[rd_ptr_q][ENT_W-1:data_width];
   assign bus.in_flight = in_flight_q;
   assign bus.err_ovf   = err_ovf_q;
endmodule

// File: tb/tb_lp_pipe_issue_ctrl.sv
// Self-checking bench for lp_pipe_issue_ctrl: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_lp_pipe_issue_ctrl;
   localparam int DW = 32;
   localparam int IW = 8;
   localparam int MO = 8;
   localparam int DP = 4;
`ifdef LP_PIPE_ISSUE_ID_CHECK_EN
   localparam bit ID_CHK = 1'b1;
`else
   localparam bit ID_CHK = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lp_pipe_issue_if #(.data_width(DW), .id_width(IW), .max_outstanding(MO), .depth(DP)) bus ();

   lp_pipe_issue_ctrl #(.data_width(DW), .id_width(IW), .max_outstanding(MO), .depth(DP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: launched-ID queue, result FIFO queues, counters and sticky flags.
   int          m_next_id, m_inflight, m_exp_id;
   bit          m_err_ovf, m_err_id;
   logic [IW-1:0] l_q[$];
   logic [IW-1:0] q_id[$];
   logic [DW-1:0] q_dat[$];

   bit            s_rv, s_pf, s_po, s_push, s_rr;
   logic [IW-1:0] s_aid;
   logic [DW-1:0] s_dat;
   bit            e_ready, e_launch, e_acc, e_valid;

   task automatic model_reset();
      m_next_id = 0; m_inflight = 0; m_exp_id = 0;
      m_err_ovf = 1'b0; m_err_id = 1'b0;
      l_q.delete(); q_id.delete(); q_dat.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_valid = 1'b0; bus.pipe_full = 1'b0; bus.pipe_ovf = 1'b0; bus.arrive = 1'b0;
      bus.arrive_id = '0; bus.push_out_n = 1'b1; bus.res_data = '0; bus.rsp_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive one cycle's inputs at the falling edge and compute expected combinational outputs.
   task automatic drive(input bit rv, input bit pf, input bit po, input bit push, input bit rr,
                        input bit bad);
      @(negedge clk);
      s_rv = rv; s_pf = pf; s_po = po; s_push = push; s_rr = rr;
      s_aid = (l_q.size() > 0) ? l_q[0] : '0;
      if (bad) s_aid = s_aid + 8'd1;
      s_dat = $urandom;
      bus.req_valid = rv; bus.pipe_full = pf; bus.pipe_ovf = po; bus.arrive = push;
      bus.arrive_id = s_aid; bus.push_out_n = !push; bus.res_data = s_dat; bus.rsp_ready = rr;
      e_ready  = !pf && (m_inflight < MO);
      e_launch = rv && e_ready;
      e_acc    = (q_id.size() == DP);
      e_valid  = (q_id.size() != 0);
      #1;
   endtask

   // Advance to the rising edge and apply the specification's rules to the model.
   task automatic tick();
      bit full, popping;
      @(posedge clk);
      full    = (q_id.size() == DP);
      popping = (q_id.size() != 0) && s_rr;
      if (e_launch) begin
         l_q.push_back(IW'(m_next_id));
         m_next_id = (m_next_id + 1) % 256;
      end
      if (s_po) m_err_ovf = 1'b1;
      if (popping) begin
         void'(q_id.pop_front());
         void'(q_dat.pop_front());
      end
      if (s_push) begin
         if (l_q.size() > 0) void'(l_q.pop_front());
         if (full) begin
            m_err_ovf = 1'b1;
         end else begin
            q_id.push_back(s_aid);
            q_dat.push_back(s_dat);
            if (s_aid != IW'(m_exp_id)) m_err_id = 1'b1;
            m_exp_id = (m_exp_id + 1) % 256;
         end
      end
      if (e_launch && !s_push) m_inflight++;
      else if (!e_launch && s_push && m_inflight > 0) m_inflight--;
   endtask

   task automatic test_reset();
      do_reset();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (bus.in_flight !== 4'd0) begin errors++; $display("FAIL reset_in_flight got %0d exp 0", bus.in_flight); end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", bus.rsp_valid); end
      checks++; if (bus.accept_n !== 1'b0) begin errors++; $display("FAIL reset_accept_n got %0b exp 0", bus.accept_n); end
      checks++; if (bus.launch_id !== 8'd0) begin errors++; $display("FAIL reset_launch_id got %0d exp 0", bus.launch_id); end
      checks++; if (bus.launch !== 1'b0) begin errors++; $display("FAIL reset_launch got %0b exp 0", bus.launch); end
      checks++; if ({bus.err_ovf, bus.err_id} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b exp 00", {bus.err_ovf, bus.err_id}); end
      checks++; if ({bus.rsp_id, bus.rsp_data} !== 40'd0) begin errors++; $display("FAIL reset_rsp got %h exp 0", {bus.rsp_id, bus.rsp_data}); end
      tick();
   endtask

   task automatic test_pipe_ovf();
      do_reset();
      drive(0, 0, 1, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (bus.err_ovf !== 1'b1) begin errors++; $display("FAIL pipe_ovf_sticky got %0b exp 1", bus.err_ovf); end
      tick();
      drive(1, 1, 0, 0, 0, 0);
      checks++; if ({bus.req_ready, bus.launch} !== 2'b00) begin errors++; $display("FAIL pipe_full_block got %b exp 00", {bus.req_ready, bus.launch}); end
      tick();
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0, 0);
         checks++; if ({bus.launch, bus.launch_id} !== {1'b1, IW'(i)}) begin errors++; $display("FAIL b2b_launch got %b/%0d exp 1/%0d", bus.launch, bus.launch_id, i); end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (bus.in_flight !== 4'd3) begin errors++; $display("FAIL b2b_in_flight got %0d exp 3", bus.in_flight); end
      tick();
   endtask

   task automatic test_max_outstanding();
      do_reset();
      for (int i = 0; i < MO; i++) begin drive(1, 0, 0, 0, 0, 0); tick(); end
      drive(1, 0, 0, 0, 0, 0);
      checks++; if ({bus.req_ready, bus.launch} !== 2'b00) begin errors++; $display("FAIL max_ready got %b exp 00", {bus.req_ready, bus.launch}); end
      checks++; if (bus.in_flight !== 4'd8) begin errors++; $display("FAIL max_in_flight got %0d exp 8", bus.in_flight); end
      tick();
      drive(0, 0, 0, 1, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL max_free_slot got %0b exp 1", bus.req_ready); end
      checks++; if (bus.in_flight !== 4'd7) begin errors++; $display("FAIL max_in_flight_dec got %0d exp 7", bus.in_flight); end
      tick();
   endtask

   task automatic test_fifo_full_drop();
      do_reset();
      for (int i = 0; i < 5; i++) begin drive(1, 0, 0, 0, 0, 0); tick(); end
      for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 1, 0, 0); tick(); end
      drive(0, 0, 0, 0, 0, 0);
      checks++; if ({bus.accept_n, bus.err_ovf} !== 2'b10) begin errors++; $display("FAIL full_accept_n got %b exp 10", {bus.accept_n, bus.err_ovf}); end
      tick();
      drive(0, 0, 0, 1, 0, 0); tick();
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (bus.err_ovf !== 1'b1) begin errors++; $display("FAIL drop_err_ovf got %0b exp 1", bus.err_ovf); end
      checks++; if (bus.in_flight !== 4'd0) begin errors++; $display("FAIL drop_in_flight got %0d exp 0", bus.in_flight); end
      tick();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if ({bus.rsp_id, bus.rsp_data} !== {q_id[0], q_dat[0]}) begin errors++; $display("FAIL full_head got %h exp %h", {bus.rsp_id, bus.rsp_data}, {q_id[0], q_dat[0]}); end
      tick();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (bus.accept_n !== 1'b0) begin errors++; $display("FAIL pop_accept_n got %0b exp 0", bus.accept_n); end
      while (q_id.size() > 0) begin
         checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, q_id[0], q_dat[0]}) begin errors++; $display("FAIL full_drain got %h exp %h", {bus.rsp_id, bus.rsp_data}, {q_id[0], q_dat[0]}); end
         tick();
         drive(0, 0, 0, 0, 1, 0);
      end
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL full_empty got %0b exp 0", bus.rsp_valid); end
      tick();
   endtask

   task automatic test_push_pop_same();
      do_reset();
      for (int i = 0; i < 8; i++) begin drive(1, 0, 0, 0, 0, 0); tick(); end
      for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 1, 0, 0); tick(); end
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 0, 1, 1, 0);
         checks++; if ({bus.accept_n, bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {2'b01, q_id[0], q_dat[0]}) begin errors++; $display("FAIL pp_head got %b %b %h exp 0 1 %h", bus.accept_n, bus.rsp_valid, {bus.rsp_id, bus.rsp_data}, {q_id[0], q_dat[0]}); end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 0, 1, 0);
         checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, q_id[0], q_dat[0]}) begin errors++; $display("FAIL pp_drain got %h exp %h", {bus.rsp_id, bus.rsp_data}, {q_id[0], q_dat[0]}); end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0);
      checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL pp_count2 got %0b exp 0", bus.rsp_valid); end
      tick();
   endtask

   task automatic test_id_check();
      do_reset();
      for (int i = 0; i < 6; i++) begin drive(1, 0, 0, 0, 0, 0); tick(); end
      for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 1, 1, 0); tick(); end
      drive(0, 0, 0, 1, 1, 1);
      checks++; if (bus.err_id !== 1'b0) begin errors++; $display("FAIL id_before got %0b exp 0", bus.err_id); end
      checks++; if (bus.arrive_id !== 8'd5) begin errors++; $display("FAIL id_stim got %0d exp 5", bus.arrive_id); end
      tick();
      drive(0, 0, 0, 0, 1, 0);
      checks++; if (bus.err_id !== ID_CHK) begin errors++; $display("FAIL id_err got %0b exp %0b", bus.err_id, ID_CHK); end
      tick();
   endtask

   task automatic test_random();
      bit rv, pf, push, rr;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rv   = ($urandom_range(0, 3) != 0);
         pf   = ($urandom_range(0, 7) == 0);
         push = (m_inflight > 0) && ($urandom_range(0, 1) == 1);
         rr   = ($urandom_range(0, 2) != 0);
         drive(rv, pf, 0, push, rr, 0);
         checks++; if ({bus.req_ready, bus.launch} !== {e_ready, e_launch}) begin errors++; $display("FAIL rnd_launch c=%0d got %b exp %b", c, {bus.req_ready, bus.launch}, {e_ready, e_launch}); end
         checks++; if (bus.launch_id !== IW'(m_next_id)) begin errors++; $display("FAIL rnd_launch_id c=%0d got %0d exp %0d", c, bus.launch_id, m_next_id); end
         checks++; if ({bus.accept_n, bus.rsp_valid} !== {e_acc, e_valid}) begin errors++; $display("FAIL rnd_fifo c=%0d got %b exp %b", c, {bus.accept_n, bus.rsp_valid}, {e_acc, e_valid}); end
         checks++; if (bus.in_flight !== 4'(m_inflight)) begin errors++; $display("FAIL rnd_in_flight c=%0d got %0d exp %0d", c, bus.in_flight, m_inflight); end
         checks++; if ({bus.err_ovf, bus.err_id} !== {m_err_ovf, m_err_id & ID_CHK}) begin errors++; $display("FAIL rnd_errs c=%0d got %b exp %b", c, {bus.err_ovf, bus.err_id}, {m_err_ovf, m_err_id & ID_CHK}); end
         if (e_valid) begin
            checks++; if ({bus.rsp_id, bus.rsp_data} !== {q_id[0], q_dat[0]}) begin errors++; $display("FAIL rnd_head c=%0d got %h exp %h", c, {bus.rsp_id, bus.rsp_data}, {q_id[0], q_dat[0]}); end
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 5; i++) begin drive(1, 0, 0, 0, 0, 0); tick(); end
      for (int i = 0; i < 2; i++) begin drive(0, 0, 0, 1, 0, 0); tick(); end
      drive(0, 0, 0, 0, 0, 0);
      checks++; if ({bus.in_flight, bus.rsp_valid} !== {4'd3, 1'b1}) begin errors++; $display("FAIL ar_setup got %0d/%0b exp 3/1", bus.in_flight, bus.rsp_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if ({bus.in_flight, bus.rsp_valid, bus.accept_n} !== {4'd0, 2'b00}) begin errors++; $display("FAIL ar_state got %0d/%0b/%0b exp 0/0/0", bus.in_flight, bus.rsp_valid, bus.accept_n); end
      checks++; if (bus.launch_id !== 8'd0) begin errors++; $display("FAIL ar_next_id got %0d exp 0", bus.launch_id); end
      checks++; if ({bus.rsp_id, bus.rsp_data} !== 40'd0) begin errors++; $display("FAIL ar_rsp got %h exp 0", {bus.rsp_id, bus.rsp_data}); end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_pipe_ovf();
      test_back_to_back();
      test_max_outstanding();
      test_fifo_full_drop();
      test_push_pop_same();
      test_id_check();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
